// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolver: default width, FSM
// state encoding, chunk-count arithmetic and the full-adder cell.
package csa_pkg;

   localparam int CSA_WIDTH = 63;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Integer ceiling division, used to size the chunk count.
   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   // One-bit full adder: returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
      return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
   endfunction

endpackage

// File: rtl/csa_cpa_chunk.sv
// CHUNK-bit ripple-carry adder built from the package full-adder cell.
// Purely combinational; the resolver feeds it one chunk per cycle.
module csa_cpa_chunk
   import csa_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic c_s;

   // Ripple the carry through CHUNK full-adder cells, LSB first.
   always_comb begin
      c_s = cin;
      s   = '0;
      for (int i = 0; i < CHUNK; i++) begin
         {c_s, s[i]} = full_add(a[i], b[i], c_s);
      end
      cout = c_s;
   end

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save (sum, carry) pair into a binary result with a
// multi-cycle chunked carry-propagate add. One operation in flight at a
// time: accept in IDLE, one chunk per RUN cycle, hold the result in DONE.
module csa_resolver
   import csa_pkg::*;
#(
   parameter int WIDTH = CSA_WIDTH,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [WIDTH-1:0] in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout
);

   localparam int              NCHUNK   = ceil_div(WIDTH, CHUNK);
   localparam int              IDXW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int              LAST_W   = WIDTH - (NCHUNK - 1) * CHUNK;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

   logic [1:0]       state_q,     state_d;
   logic [WIDTH-1:0] sum_q,       sum_d;
   logic [WIDTH-1:0] carry_q,     carry_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic [IDXW-1:0]  idx_q,       idx_d;
   logic             cy_q,        cy_d;
   logic             cout_q,      cout_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [31:0]      base_s;
   logic [CHUNK-1:0] op_a_s;
   logic [CHUNK-1:0] op_b_s;
   logic [CHUNK-1:0] chunk_sum_s;
   logic             chunk_cout_s;
   logic             last_cout_s;
   logic [WIDTH-1:0] lane_mask_s;
   logic [WIDTH-1:0] merged_s;

   // Select the current chunk of both operands; bits shifted in above WIDTH
   // are zero, which masks the unused upper lanes of a short final chunk.
   always_comb begin
      base_s = 32'(idx_q) * 32'(CHUNK);
      op_a_s = CHUNK'(sum_q >> base_s);
      op_b_s = CHUNK'(carry_q >> base_s);
   end

   csa_cpa_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a    (op_a_s),
      .b    (op_b_s),
      .cin  (cy_q),
      .s    (chunk_sum_s),
      .cout (chunk_cout_s)
   );

   // The carry out of bit WIDTH-1: for a short final chunk the zero upper
   // lanes pass it straight through, so it lands on sum lane LAST_W.
   if (LAST_W == CHUNK) begin : g_full_last
      assign last_cout_s = chunk_cout_s;
   end else begin : g_part_last
      assign last_cout_s = chunk_sum_s[LAST_W];
   end

   // Merge the freshly added chunk into the result at its bit position.
   always_comb begin
      lane_mask_s = WIDTH'({CHUNK{1'b1}}) << base_s;
      merged_s    = (result_q & ~lane_mask_s) | ((WIDTH'(chunk_sum_s) << base_s) & lane_mask_s);
   end

   // Next-state and datapath update for the IDLE/RUN/DONE sequence.
   always_comb begin
      state_d  = state_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      result_d = result_q;
      idx_d    = idx_q;
      cy_d     = cy_q;
      cout_d   = cout_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_RUN;
               sum_d   = in_sum;
               carry_d = in_carry;
               idx_d   = '0;
               cy_d    = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            result_d = merged_s;
            cy_d     = chunk_cout_s;
            if (idx_q == IDX_LAST) begin
               state_d = S_DONE;
               idx_d   = '0;
               cout_d  = last_cout_s;
            end else begin
               idx_d   = idx_q + IDXW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Handshake outputs decoded from the next state so they are registered.
   always_comb begin
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      case (state_d)
         S_IDLE:  in_ready_d  = 1'b1;
         S_RUN:   in_ready_d  = 1'b0;
         S_DONE:  out_valid_d = 1'b1;
         default: in_ready_d  = 1'b0;
      endcase
   end

   // State, operand, result and handshake registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sum_q       <= '0;
         carry_q     <= '0;
         result_q    <= '0;
         idx_q       <= '0;
         cy_q        <= 1'b0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         result_q    <= result_d;
         idx_q       <= idx_d;
         cy_q        <= cy_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_result = result_q;
   assign out_cout   = cout_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: three instances (CHUNK 8, 1, 63)
// checked every cycle against a transaction-level model of the handshake,
// the latency rule and the plain 64-bit sum of the operands.
module tb_csa_resolver;

   localparam int NL = 3;
   localparam int W  = 63;

   int nch [NL] = '{8, 63, 1};

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid   [NL];
   logic           in_ready   [NL];
   logic [W-1:0]   in_sum     [NL];
   logic [W-1:0]   in_carry   [NL];
   logic           out_valid  [NL];
   logic           out_ready  [NL];
   logic [W-1:0]   out_result [NL];
   logic           out_cout   [NL];

   bit             busy     [NL];
   bit             seen     [NL];
   int             acc_cyc  [NL];
   int             done_cyc [NL];
   int             lat      [NL];
   int             ov_cnt   [NL];
   logic [63:0]    exp_val  [NL];
   logic [W-1:0]   got_res  [NL];
   logic           got_cout [NL];

   int             checks = 0;
   int             errors = 0;
   int             cyc    = 0;
   bit             rand_on = 1'b0;
   bit             exp_ov;
   logic [63:0]    m;
   int             snap;
   int             n;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   csa_resolver #(.WIDTH(63), .CHUNK(8)) u_c8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_sum(in_sum[0]), .in_carry(in_carry[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_result(out_result[0]), .out_cout(out_cout[0])
   );

   csa_resolver #(.WIDTH(63), .CHUNK(1)) u_c1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_sum(in_sum[1]), .in_carry(in_carry[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_result(out_result[1]), .out_cout(out_cout[1])
   );

   csa_resolver #(.WIDTH(63), .CHUNK(63)) u_c63 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_sum(in_sum[2]), .in_carry(in_carry[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_result(out_result[2]), .out_cout(out_cout[2])
   );

   function automatic logic [63:0] ref_add(input logic [W-1:0] s, input logic [W-1:0] c);
      return {1'b0, s} + {1'b0, c};
   endfunction

   task automatic chk(input string name, input int l, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s lane%0d got %0h want %0h (t=%0t)", name, l, act, want, $time);
      end
   endtask

   // Per-cycle comparison against the transaction model.
   always @(negedge clk) begin
      for (int l = 0; l < NL; l++) begin
         if (rst) begin
            busy[l] = 1'b0;
            seen[l] = 1'b0;
         end else begin
            exp_ov = busy[l] && ((cyc - acc_cyc[l]) >= nch[l] + 1);
            chk("in_ready", l, 64'(in_ready[l]), 64'(!busy[l]));
            chk("out_valid", l, 64'(out_valid[l]), 64'(exp_ov));
            if (exp_ov && out_valid[l]) begin
               chk("result", l, {out_cout[l], out_result[l]}, exp_val[l]);
            end
            if (out_valid[l]) begin
               ov_cnt[l]++;
               if (busy[l] && !seen[l]) begin
                  lat[l]  = cyc - acc_cyc[l];
                  seen[l] = 1'b1;
               end
            end
            if (!busy[l]) begin
               if (in_valid[l]) begin
                  busy[l]    = 1'b1;
                  seen[l]    = 1'b0;
                  acc_cyc[l] = cyc;
                  exp_val[l] = ref_add(in_sum[l], in_carry[l]);
               end
            end else if (exp_ov && out_ready[l]) begin
               busy[l]     = 1'b0;
               done_cyc[l] = cyc;
               got_res[l]  = out_result[l];
               got_cout[l] = out_cout[l];
            end
         end
      end
   end

   task automatic send(input int l, input logic [W-1:0] s, input logic [W-1:0] c);
      bit hs = 1'b0;
      int k  = 0;
      in_sum[l]   = s;
      in_carry[l] = c;
      in_valid[l] = 1'b1;
      while (!hs && k < 3000) begin
         @(negedge clk);
         hs = (in_ready[l] === 1'b1) && !rst;
         @(posedge clk);
         #1;
         k++;
      end
      in_valid[l] = 1'b0;
      chk("accept_timeout", l, 64'(hs), 64'd1);
   endtask

   task automatic wait_idle(input int l);
      int k = 0;
      while (busy[l] && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("idle_timeout", l, 64'(busy[l]), 64'd0);
   endtask

   function automatic logic [W-1:0] rand_op();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0:       r = '1;
         1:       r = '0;
         2:       r = r & 64'h0000_0000_0000_00FF;
         default: r = r;
      endcase
      return r[W-1:0];
   endfunction

   task automatic rand_lane(input int l, input int cnt);
      for (int k = 0; k < cnt; k++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send(l, rand_op(), rand_op());
      end
   endtask

   // Random downstream back-pressure during the random phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_on) begin
            for (int l = 0; l < NL; l++) out_ready[l] = ($urandom_range(0, 3) != 0);
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int l = 0; l < NL; l++) begin
         in_valid[l]  = 1'b0;
         in_sum[l]    = '0;
         in_carry[l]  = '0;
         out_ready[l] = 1'b1;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
         chk("rst_in_ready", l, 64'(in_ready[l]), 64'd1);
         chk("rst_out_valid", l, 64'(out_valid[l]), 64'd0);
         chk("rst_out_result", l, 64'(out_result[l]), 64'd0);
         chk("rst_out_cout", l, 64'(out_cout[l]), 64'd0);
      end
      @(posedge clk);
      #1;

      // Pin the reference model with hand-computed sums
      m = ref_add(63'h7FFF_FFFF_FFFF_FFFF, 63'h1);
      chk("model_pin_ripple", 0, m, 64'h8000_0000_0000_0000);
      m = ref_add(63'h123, 63'h0F0);
      chk("model_pin_simple", 0, m, 64'h0000_0000_0000_0213);

      // Full carry ripple on every chunking
      for (int l = 0; l < NL; l++) begin
         send(l, 63'h7FFF_FFFF_FFFF_FFFF, 63'h1);
         wait_idle(l);
         chk("ripple_result", l, 64'(got_res[l]), 64'd0);
         chk("ripple_cout", l, 64'(got_cout[l]), 64'd1);
      end
      chk("latency_c8", 0, 64'(lat[0]), 64'd9);
      chk("latency_c1", 1, 64'(lat[1]), 64'd64);
      chk("latency_c63", 2, 64'(lat[2]), 64'd2);

      // Simple add
      send(0, 63'h123, 63'h0F0);
      wait_idle(0);
      chk("simple_result", 0, 64'(got_res[0]), 64'h213);
      chk("simple_cout", 0, 64'(got_cout[0]), 64'd0);

      // Backpressure: hold DONE 5 cycles while a second operand waits
      out_ready[0] = 1'b0;
      send(0, 63'h5555_5555_5555_5555, 63'h2AAA_AAAA_AAAA_AAAB);
      n = 0;
      while (!out_valid[0] && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("bp_valid_seen", 0, 64'(out_valid[0]), 64'd1);
      fork
         send(0, 63'h0FF, 63'h001);
         begin
            repeat (5) begin
               @(posedge clk);
               #1;
            end
            out_ready[0] = 1'b1;
         end
      join
      chk("bp_result", 0, 64'(got_res[0]), 64'd0);
      chk("bp_cout", 0, 64'(got_cout[0]), 64'd1);
      chk("bp_accept_after_out", 0, 64'(acc_cyc[0] - done_cyc[0]), 64'd1);
      wait_idle(0);
      chk("bp_second_result", 0, 64'(got_res[0]), 64'h100);

      // Reset during RUN cycle 4 aborts the operation
      snap = ov_cnt[0];
      send(0, 63'h7FFF_FFFF_FFFF_FFFF, 63'h7FFF_FFFF_FFFF_FFFF);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_out_result", 0, 64'(out_result[0]), 64'd0);
      chk("abort_out_cout", 0, 64'(out_cout[0]), 64'd0);
      repeat (15) begin
         @(posedge clk);
         #1;
      end
      chk("abort_no_valid", 0, 64'(ov_cnt[0] - snap), 64'd0);
      send(0, 63'h1, 63'h1);
      wait_idle(0);
      chk("after_abort_result", 0, 64'(got_res[0]), 64'h2);
      chk("after_abort_latency", 0, 64'(lat[0]), 64'd9);

      // Random operands with valid/ready stalls on all chunkings
      rand_on = 1'b1;
      fork
         rand_lane(0, 3000);
         rand_lane(1, 150);
         rand_lane(2, 4000);
      join
      rand_on = 1'b0;
      @(posedge clk);
      #2;
      for (int l = 0; l < NL; l++) out_ready[l] = 1'b1;
      for (int l = 0; l < NL; l++) wait_idle(l);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
